// File: rtl/serial_detect_pkg.sv
// Shared types and default sizing for the serial "11" detector scheduler.
package serial_detect_pkg;
    localparam int NCH_DEF = 4;
    localparam int W_DEF   = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
endpackage

// File: rtl/serial_detect_scheduler_if.sv
// Request/result handshake bundle between requesters, the scheduler and downstream.
interface serial_detect_scheduler_if
    import serial_detect_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
);
    localparam int CW  = $clog2(W);
    localparam int IDW = $clog2(NCH);

    logic [NCH-1:0]   req_valid;
    logic [NCH*W-1:0] req_data;
    logic [NCH-1:0]   req_ready;
    logic             res_valid;
    logic [IDW-1:0]   res_ch;
    logic [CW-1:0]    res_count;
    logic             res_ready;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_ch, res_count
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_ch, res_count
    );
endinterface

// File: rtl/pair_detect_core.sv
// Bit-serial Mealy detector for adjacent "11"; hit is combinational on the current bit.
module pair_detect_core (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic hit
);
    logic prev_one_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_one_reg <= 1'b0;
        end else if (en) begin
            prev_one_reg <= din;
        end
    end

    assign hit = en & din & prev_one_reg;
endmodule

// File: rtl/serial_detect_scheduler.sv
// Round-robin time-sharing of one serial "11" detector among NCH word requesters.
module serial_detect_scheduler
    import serial_detect_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_detect_scheduler_if.slave    bus,
    output logic                        busy
);
    localparam int CW  = $clog2(W);
    localparam int IDW = $clog2(NCH);

    state_t         state_reg, state_next;
    logic [W-1:0]   word_reg, word_next;
    logic [IDW-1:0] ch_reg, ch_next;
    logic [CW-1:0]  bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [IDW-1:0] res_ch_reg, res_ch_next;
    logic [CW-1:0]  res_count_reg, res_count_next;
    logic           res_valid_reg, res_valid_next;
    logic [IDW-1:0] last_grant_reg, last_grant_next;

    logic [W-1:0]   word_arr [NCH];
    logic           grant_en;
    logic [IDW-1:0] grant_idx;
    logic           det_clr, det_en, det_hit;

    // First valid channel after the last one served, wrapping modulo NCH.
    function automatic logic [IDW-1:0] rr_pick(input logic [NCH-1:0] valid,
                                               input logic [IDW-1:0] last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = (int'(last) + i) % NCH;
            if (!found && valid[IDW'(idx)]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign grant_en  = (state_reg == IDLE) && (|bus.req_valid) && !rst;
    assign grant_idx = rr_pick(bus.req_valid, last_grant_reg);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign word_arr[gi]      = bus.req_data[gi*W +: W];
            assign bus.req_ready[gi] = grant_en && (grant_idx == IDW'(gi));
        end
    endgenerate

    pair_detect_core u_core (
        .clk (clk),
        .rst (rst),
        .clr (det_clr),
        .en  (det_en),
        .din (word_reg[W-1]),
        .hit (det_hit)
    );

    always_comb begin
        state_next      = state_reg;
        word_next       = word_reg;
        ch_next         = ch_reg;
        bit_cnt_next    = bit_cnt_reg;
        count_next      = count_reg;
        res_ch_next     = res_ch_reg;
        res_count_next  = res_count_reg;
        res_valid_next  = res_valid_reg;
        last_grant_next = last_grant_reg;
        det_clr         = 1'b0;
        det_en          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_en) begin
                    word_next    = word_arr[grant_idx];
                    ch_next      = grant_idx;
                    bit_cnt_next = CW'(W - 1);
                    count_next   = '0;
                    det_clr      = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                det_en       = 1'b1;
                word_next    = {word_reg[W-2:0], 1'b0};
                count_next   = count_reg + CW'(det_hit);
                bit_cnt_next = bit_cnt_reg - 1'b1;
                if (bit_cnt_reg == '0) begin
                    res_count_next = count_reg + CW'(det_hit);
                    res_ch_next    = ch_reg;
                    res_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                if (bus.res_ready) begin
                    res_valid_next  = 1'b0;
                    last_grant_next = res_ch_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            word_reg       <= '0;
            ch_reg         <= '0;
            bit_cnt_reg    <= '0;
            count_reg      <= '0;
            res_ch_reg     <= '0;
            res_count_reg  <= '0;
            res_valid_reg  <= 1'b0;
            last_grant_reg <= IDW'(NCH - 1);
        end else begin
            state_reg      <= state_next;
            word_reg       <= word_next;
            ch_reg         <= ch_next;
            bit_cnt_reg    <= bit_cnt_next;
            count_reg      <= count_next;
            res_ch_reg     <= res_ch_next;
            res_count_reg  <= res_count_next;
            res_valid_reg  <= res_valid_next;
            last_grant_reg <= last_grant_next;
        end
    end

    assign bus.res_valid = res_valid_reg;
    assign bus.res_ch    = res_ch_reg;
    assign bus.res_count = res_count_reg;
    assign busy          = (state_reg != IDLE);
endmodule

// File: doc/serial_detect_scheduler.md
Name: serial_detect_scheduler

Overview:
Time-shares one bit-serial "11" Mealy pattern-detector engine among NCH requesters. Each requester offers a W-bit word over a valid/ready handshake. A round-robin arbiter grants one word at a time and the controller shifts it MSB-first through the shared detector. The controller then returns the overlapping-match count tagged with the channel id over a second valid/ready handshake. It sits between the parallel capture logic and downstream statistics.

Parameters:
NCH, 4, number of requesting channels (>=2)
W, 8, word width in bits (>=2)
CW, $clog2(W), width of match count (max count W-1)
IDW, $clog2(NCH), width of channel id

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NCH  per-channel word offered
req_data  input  NCH*W  channel c word at bits [c*W +: W]
req_ready  output  NCH  one-hot accept strobe, combinational
res_valid  output  1  result available
res_ch  output  IDW  channel the result belongs to
res_count  output  CW  number of overlapping "11" pairs in the word
res_ready  input  1  downstream accepts result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE, res_valid=0, res_ch=0, res_count=0, req_ready=0, busy=0, detector cleared, last_grant=NCH-1 so channel 0 has top priority. Reset mid-operation abandons the word with no result.
- FSM states: IDLE, SHIFT, RESP.
- IDLE: if any req_valid, grant the first valid channel searching last_grant+1, +2, ... with wrap modulo NCH. Assert req_ready[g] for that cycle only; handshake completes that cycle. Latch req_data word g and id g, clear bit counter, count and detector. Go to SHIFT. No valid: stay, req_ready=0.
- SHIFT: exactly W cycles, bit W-1 first down to bit 0. Detector hit = en & din & prev_one (Mealy, combinational on the current bit). prev_one <= din each enabled cycle. On hit, count += 1. After bit 0, go to RESP with res_count and res_ch registered.
- RESP: res_valid=1, res_ch and res_count held stable while res_ready=0. On res_valid&res_ready: res_valid<=0, last_grant<=res_ch, go to IDLE.
- Latency: accept at cycle T, res_valid first high at T+W+1. Minimum issue interval is W+2 cycles.
- The detector is cleared at every word start: no matches across word boundaries.
- Overlapping counting: 111 gives 2. Count never overflows (max W-1).
- req_valid from non-granted channels is ignored outside IDLE. A requester may hold or drop valid freely; only the IDLE-cycle value matters.
- res_ready while not in RESP has no effect.

Decomposition:
- Package serial_detect_pkg: state enum (IDLE, SHIFT, RESP) and the default NCH/W constants.
- Sub-module pair_detect_core: clk, rst, clr, en, din -> hit. Holds the prev_one register; Mealy output. The round-robin pick stays inline as a function.

Test Plan:
- Ch0 only, data 8'hB6 (10110110) -> req_ready[0] pulses one cycle; res_valid 9 cycles later; res_ch=0, res_count=2.
- Ch1 sends 8'hFF, then 8'h00, then 8'hAA -> counts 7, 0, 0 in order, each res_ch=1.
- All four channels valid continuously, res_ready=1 -> grants and res_ch sequence 0,1,2,3,0,1; no channel granted twice before the others.
- Ch0 sends 8'h01, then 8'h80 -> both counts 0 (boundary not counted). res_ready held low for 5 cycles in RESP -> res_valid/res_ch/res_count stable, no new req_ready pulse.
- rst asserted on 4th SHIFT cycle of ch2 word 8'hFF -> next cycle all outputs at reset values. With ch2 and ch0 valid after reset, ch0 is granted first.
